// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encoding and the linear round helpers
// (ShiftRows, MixColumns, xtime) used by the iterative encryption core.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] state_t;
    typedef logic [3:0]   round_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n of the block sits at bits [127-8n -: 8]; byte n is row n%4, column n/4.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Same table as the key expansion unit uses for SubWord.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 occupies the top byte of the packed table.
    assign o_byte = SBOX_TABLE[11'd2047 - {i_byte, 3'b000} -: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core, one round per clock, valid/ready on both sides.
// Define AES_KEY_LATCH_EN to capture the round keys at accept so key inputs may change mid-block.
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    input  logic [127:0] key2,
    input  logic [127:0] key3,
    input  logic [127:0] key4,
    input  logic [127:0] key5,
    input  logic [127:0] key6,
    input  logic [127:0] key7,
    input  logic [127:0] key8,
    input  logic [127:0] key9,
    input  logic [127:0] key10,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    fsm_t   r_state;
    fsm_t   w_nextState;
    state_t r_data;
    round_t r_round;

    state_t w_keys [NR];
    state_t w_roundKey;
    state_t w_subBytes;
    state_t w_shifted;
    state_t w_mixed;
    state_t w_roundOut;
    logic   w_lastRound;
    logic   w_accept;

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_lastRound = (r_round == round_t'(NR));

`ifdef AES_KEY_LATCH_EN
    // key0 is consumed at the accept edge itself, so only keys 1..10 need holding.
    state_t r_keyBank [NR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) begin
                r_keyBank[k] <= '0;
            end
        end else if (w_accept) begin
            r_keyBank[0] <= key1;
            r_keyBank[1] <= key2;
            r_keyBank[2] <= key3;
            r_keyBank[3] <= key4;
            r_keyBank[4] <= key5;
            r_keyBank[5] <= key6;
            r_keyBank[6] <= key7;
            r_keyBank[7] <= key8;
            r_keyBank[8] <= key9;
            r_keyBank[9] <= key10;
        end
    end

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            w_keys[k] = r_keyBank[k];
        end
    end
`else
    always_comb begin
        w_keys[0] = key1;
        w_keys[1] = key2;
        w_keys[2] = key3;
        w_keys[3] = key4;
        w_keys[4] = key5;
        w_keys[5] = key6;
        w_keys[6] = key7;
        w_keys[7] = key8;
        w_keys[8] = key9;
        w_keys[9] = key10;
    end
`endif

    always_comb begin
        w_roundKey = '0;
        for (int k = 0; k < NR; k++) begin
            if (r_round == round_t'(k + 1)) begin
                w_roundKey = w_keys[k];
            end
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_data[127-8*gi -: 8]),
            .o_byte (w_subBytes[127-8*gi -: 8])
        );
    end

    // The final round skips MixColumns.
    assign w_shifted  = shift_rows(w_subBytes);
    assign w_mixed    = mix_columns(w_shifted);
    assign w_roundOut = (w_lastRound ? w_shifted : w_mixed) ^ w_roundKey;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_nextState = ROUND;
            ROUND:   if (w_lastRound) w_nextState = DONE;
            DONE:    if (out_ready)   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_round <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data ^ key0;
                        r_round <= round_t'(1);
                    end
                end
                ROUND: begin
                    r_data <= w_roundOut;
                    if (!w_lastRound) begin
                        r_round <= r_round + round_t'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_round <= '0;
                    end
                end
                default: begin
                    r_round <= '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        out_data  = (r_state == DONE) ? r_data : '0;
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, backpressure, back-to-back,
// mid-round reset and random blocks checked against a GF(2^8)-derived AES reference model.
module tb_aes_encrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] roundKeys [11];
    logic [7:0]   tbSbox [256];

    int compareCount = 0;
    int failCount    = 0;
    int cycleCount   = 0;
    int acceptCycle  = 0;
    int firstAccept  = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_encrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key0      (roundKeys[0]),
        .key1      (roundKeys[1]),
        .key2      (roundKeys[2]),
        .key3      (roundKeys[3]),
        .key4      (roundKeys[4]),
        .key5      (roundKeys[5]),
        .key6      (roundKeys[6]),
        .key7      (roundKeys[7]),
        .key8      (roundKeys[8]),
        .key9      (roundKeys[9]),
        .key10     (roundKeys[10]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: S-box built from the field inverse plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sboxValue(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] rot;
        logic [7:0] s;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        s   = inv ^ 8'h63;
        rot = inv;
        for (int n = 0; n < 4; n++) begin
            rot = {rot[6:0], rot[7]};
            s   = s ^ rot;
        end
        return s;
    endfunction

    task automatic loadKey(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {tbSbox[tmp[31:24]] ^ rcon, tbSbox[tmp[23:16]], tbSbox[tmp[15:8]], tbSbox[tmp[7:0]]};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++) roundKeys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] refEncrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ roundKeys[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = tbSbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd == 10) s[4*c+r] = t[4*c+r];
                    else s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                                    ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ roundKeys[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input bit holdValid);
        int waitCount;
        waitCount = 0;
        @(negedge clk);
        in_data  = pt;
        in_valid = 1'b1;
        while (!in_ready && waitCount < 50) begin
            @(negedge clk);
            waitCount++;
        end
        checkValue("accept_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        if (!holdValid) in_valid = 1'b0;
    endtask

    task automatic awaitOutput(input string tag, input logic [127:0] expected, input bit junk);
        int waitCount;
        waitCount = 0;
        @(negedge clk);
        while (!out_valid && waitCount < 40) begin
            checkValue({tag, "_busy_ready"}, 128'(in_ready), 128'd0);
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            waitCount++;
        end
        if (junk) in_valid = 1'b0;
        checkValue({tag, "_valid"}, 128'(out_valid), 128'd1);
        checkValue({tag, "_latency"}, 128'(cycleCount - acceptCycle), 128'd10);
        checkValue({tag, "_data"}, out_data, expected);
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] expected, input int delay, input bit junk);
        awaitOutput(tag, expected, junk);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkValue({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
            checkValue({tag, "_hold_data"}, out_data, expected);
            checkValue({tag, "_hold_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkValue({tag, "_idle_ready"}, 128'(in_ready), 128'd1);
        checkValue({tag, "_idle_valid"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] expected;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        for (int i = 0; i < 256; i++) tbSbox[i] = sboxValue(8'(i));
        loadKey(128'd0);

        repeat (3) @(negedge clk);
        checkValue("rst_in_ready", 128'(in_ready), 128'd1);
        checkValue("rst_out_valid", 128'(out_valid), 128'd0);
        checkValue("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("post_rst_in_ready", 128'(in_ready), 128'd1);

        $display("[TB] FIPS-197 C.1 vector");
        loadKey(C1_KEY);
        applyStimulus(C1_PT, 1'b0);
        checkOutput("c1", C1_CT, 0, 1'b0);

        $display("[TB] FIPS-197 App. B vector with 20 cycles of backpressure");
        loadKey(B_KEY);
        applyStimulus(B_PT, 1'b0);
        checkOutput("appb_bp", B_CT, 20, 1'b0);

        $display("[TB] back-to-back blocks with in_valid held high");
        loadKey(C1_KEY);
        out_ready = 1'b1;
        applyStimulus(C1_PT, 1'b1);
        firstAccept = acceptCycle;
        awaitOutput("b2b_first", C1_CT, 1'b0);
        @(posedge clk);
        #1;
        loadKey(B_KEY);
        in_data = B_PT;
        checkValue("b2b_ready_again", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        checkValue("b2b_accept_gap", 128'(acceptCycle - firstAccept), 128'd12);
        awaitOutput("b2b_second", B_CT, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkValue("b2b_idle_ready", 128'(in_ready), 128'd1);
        checkValue("b2b_idle_valid", 128'(out_valid), 128'd0);

        $display("[TB] reset in the middle of a block");
        loadKey(C1_KEY);
        applyStimulus(C1_PT, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkValue("midrst_out_valid", 128'(out_valid), 128'd0);
        checkValue("midrst_in_ready", 128'(in_ready), 128'd1);
        checkValue("midrst_out_data", out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkValue("midrst_no_output", 128'(out_valid), 128'd0);
        checkValue("midrst_ready_after", 128'(in_ready), 128'd1);
        applyStimulus(C1_PT, 1'b0);
        checkOutput("midrst_c1", C1_CT, 1, 1'b0);

`ifdef AES_KEY_LATCH_EN
        $display("[TB] key inputs zeroed one cycle after accept");
        loadKey(C1_KEY);
        applyStimulus(C1_PT, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 11; k++) roundKeys[k] = '0;
        checkOutput("latch_c1", C1_CT, 0, 1'b0);
`endif

        $display("[TB] random keys and plaintexts");
        for (int n = 0; n < 8; n++) begin
            key      = {$urandom, $urandom, $urandom, $urandom};
            pt       = {$urandom, $urandom, $urandom, $urandom};
            loadKey(key);
            expected = refEncrypt(pt);
            applyStimulus(pt, 1'b0);
            checkOutput("random", expected, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
